jump_ctrl: RTL and testbench

- Vertical-motion sequencer for the player character.
- Arbitrates two launch requests: player jump button and spring contact (`jump` level from a spring object). Spring has priority.
- Advances char_Y once per frame tick through a ground/rise/fall state machine with gravity, a ceiling, and a floor clamp.
- Its char_Y output feeds the collision objects, including the springs.

---
 rtl/jump_ctrl.sv | 177 +++++++++++++++++
 tb/tb_jump_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
// Vertical-motion sequencer: ground/rise/fall FSM that moves char_Y once per frame tick.
// Optional JUMP_CTRL_VARJUMP_EN: releasing the button cuts a button-launched rise short.
module jump_ctrl #(
  parameter int GROUND_Y   = 200,
  parameter int Y_MIN      = 0,
  parameter int JUMP_V     = 12,
  parameter int SPRING_V   = 20,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL_V = 8,
  parameter int V_W        = 6
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tick,
  input  logic       btn_jump,
  input  logic       spring_jump,
  input  logic       on_ground,
  input  logic       hit_ceiling,
  output logic [8:0] char_Y,
  output logic [1:0] state,
  output logic       airborne,
  output logic       land
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_UNUSED = 2'd3
  } state_e;

  localparam logic [9:0]     GY10     = 10'(GROUND_Y);
  localparam logic [9:0]     YMIN10   = 10'(Y_MIN);
  localparam logic [V_W-1:0] JUMP_VW  = V_W'(JUMP_V);
  localparam logic [V_W-1:0] SPRING_VW = V_W'(SPRING_V);
  localparam logic [V_W-1:0] GRAV_W   = V_W'(GRAVITY);
  localparam logic [V_W-1:0] MAXV_W   = V_W'(MAX_FALL_V);
  localparam logic [V_W:0]   GRAV_X   = (V_W+1)'(GRAVITY);
  localparam logic [V_W:0]   MAXV_X   = (V_W+1)'(MAX_FALL_V);

  state_e         state_q;
  logic [8:0]     y_q;
  logic [V_W-1:0] vel_q;
  logic           land_q;
  logic           jump_req_q;
  logic           btn_q;

  logic           btn_edge;
  logic           launch_req;
  logic [9:0]     y_ext;
  logic [9:0]     vel_ext;
  logic           rise_clamp;
  logic [9:0]     y_rise;
  logic           rise_apex;
  logic [V_W-1:0] vel_rise_nxt;
  logic [9:0]     y_sum;
  logic           fall_clamp;
  logic [9:0]     y_fall;
  logic [V_W:0]   vel_up_x;
  logic [V_W-1:0] vel_fall_nxt;
  logic           at_floor;
  logic           cut_rise;

`ifdef JUMP_CTRL_VARJUMP_EN
  logic src_q;
  assign cut_rise = src_q & ~btn_jump;
`else
  assign cut_rise = 1'b0;
`endif

  // 10-bit arithmetic so a large velocity can never wrap the Y coordinate
  always_comb begin
    btn_edge     = btn_jump & ~btn_q;
    launch_req   = jump_req_q | btn_edge;
    y_ext        = {1'b0, y_q};
    vel_ext      = 10'(vel_q);
    rise_clamp   = (y_ext <= (YMIN10 + vel_ext));
    y_rise       = rise_clamp ? YMIN10 : (y_ext - vel_ext);
    rise_apex    = (vel_q <= GRAV_W) || rise_clamp;
    vel_rise_nxt = vel_q - GRAV_W;
    y_sum        = y_ext + vel_ext;
    fall_clamp   = (y_sum >= GY10);
    y_fall       = fall_clamp ? GY10 : y_sum;
    vel_up_x     = {1'b0, vel_q} + GRAV_X;
    vel_fall_nxt = (vel_up_x >= MAXV_X) ? MAXV_W : vel_up_x[V_W-1:0];
    at_floor     = (y_ext >= GY10);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_GROUND;
      y_q        <= GY10[8:0];
      vel_q      <= '0;
      land_q     <= 1'b0;
      jump_req_q <= 1'b0;
      btn_q      <= 1'b0;
`ifdef JUMP_CTRL_VARJUMP_EN
      src_q      <= 1'b0;
`endif
    end else begin
      btn_q  <= btn_jump;
      land_q <= 1'b0;
      if (!tick) begin
        jump_req_q <= launch_req;
      end else begin
        jump_req_q <= 1'b0;
        case (state_q)
          ST_RISE: begin
            if (hit_ceiling || cut_rise) begin
              state_q <= ST_FALL;
              vel_q   <= '0;
            end else begin
              y_q <= y_rise[8:0];
              if (rise_apex) begin
                state_q <= ST_FALL;
                vel_q   <= '0;
              end else begin
                vel_q <= vel_rise_nxt;
              end
            end
          end
          ST_FALL: begin
            if (spring_jump) begin
              state_q <= ST_RISE;
              vel_q   <= SPRING_VW;
`ifdef JUMP_CTRL_VARJUMP_EN
              src_q   <= 1'b0;
`endif
            end else if (on_ground || at_floor) begin
              state_q <= ST_GROUND;
              vel_q   <= '0;
              land_q  <= 1'b1;
              y_q     <= at_floor ? GY10[8:0] : y_q;
            end else begin
              y_q <= y_fall[8:0];
              if (fall_clamp) begin
                state_q <= ST_GROUND;
                vel_q   <= '0;
                land_q  <= 1'b1;
              end else begin
                vel_q <= vel_fall_nxt;
              end
            end
          end
          default: begin
            // GROUND, and the unreachable encoding recovers as GROUND
            if (spring_jump) begin
              state_q <= ST_RISE;
              vel_q   <= SPRING_VW;
`ifdef JUMP_CTRL_VARJUMP_EN
              src_q   <= 1'b0;
`endif
            end else if (launch_req) begin
              state_q <= ST_RISE;
              vel_q   <= JUMP_VW;
`ifdef JUMP_CTRL_VARJUMP_EN
              src_q   <= 1'b1;
`endif
            end else if (!on_ground && !at_floor) begin
              state_q <= ST_FALL;
              vel_q   <= '0;
            end else begin
              state_q <= ST_GROUND;
              vel_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign char_Y   = y_q;
  assign state    = (state_q == ST_RISE || state_q == ST_FALL) ? state_q : ST_GROUND;
  assign airborne = (state_q == ST_RISE) || (state_q == ST_FALL);
  assign land     = land_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: a default instance and a Y_MIN=150 instance share stimulus,
// both checked every cycle against a plain integer model of the motion rules.
module tb_jump_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst, tick, btn_jump, spring_jump, on_ground, hit_ceiling;
  logic [8:0] y0, y1;
  logic [1:0] st0, st1;
  logic       ab0, ab1, ld0, ld1;

  int checks = 0;
  int failures = 0;

  int my[2], mv[2], mst[2];
  int ld_m[2];
  int ymin[2] = '{0, 150};
  int mbtn = 0, mreq = 0;

  always #5 sys_clk = ~sys_clk;

  jump_ctrl u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .btn_jump(btn_jump),
    .spring_jump(spring_jump), .on_ground(on_ground), .hit_ceiling(hit_ceiling),
    .char_Y(y0), .state(st0), .airborne(ab0), .land(ld0));

  jump_ctrl #(.Y_MIN(150)) u_dut_ymin (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .btn_jump(btn_jump),
    .spring_jump(spring_jump), .on_ground(on_ground), .hit_ceiling(hit_ceiling),
    .char_Y(y1), .state(st1), .airborne(ab1), .land(ld1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Motion rules: 0=ground 1=rise 2=fall, Y grows downward, floor 200
  task automatic model_update();
    int req, ny, top;
    if (sys_rst) begin
      for (int k = 0; k < 2; k++) begin
        my[k] = 200; mv[k] = 0; mst[k] = 0; ld_m[k] = 0;
      end
      mbtn = 0; mreq = 0;
    end else begin
      req = (mreq != 0 || (btn_jump && mbtn == 0)) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
        ld_m[k] = 0;
        if (tick) begin
          if (mst[k] == 1) begin
            if (hit_ceiling) begin
              mst[k] = 2; mv[k] = 0;
            end else begin
              top = 0;
              ny = my[k] - mv[k];
              if (ny <= ymin[k]) begin ny = ymin[k]; top = 1; end
              my[k] = ny;
              if (mv[k] <= 1 || top == 1) begin mst[k] = 2; mv[k] = 0; end
              else mv[k] = mv[k] - 1;
            end
          end else if (mst[k] == 2) begin
            if (spring_jump) begin
              mst[k] = 1; mv[k] = 20;
            end else if (on_ground || my[k] >= 200) begin
              mst[k] = 0; mv[k] = 0; ld_m[k] = 1;
              if (my[k] > 200) my[k] = 200;
            end else begin
              ny = my[k] + mv[k];
              if (ny >= 200) begin
                my[k] = 200; mst[k] = 0; mv[k] = 0; ld_m[k] = 1;
              end else begin
                my[k] = ny;
                mv[k] = (mv[k] + 1 > 8) ? 8 : mv[k] + 1;
              end
            end
          end else begin
            if (spring_jump) begin mst[k] = 1; mv[k] = 20; end
            else if (req == 1) begin mst[k] = 1; mv[k] = 12; end
            else if (!on_ground && my[k] < 200) begin mst[k] = 2; mv[k] = 0; end
          end
        end
      end
      mreq = tick ? 0 : req;
      mbtn = btn_jump ? 1 : 0;
    end
  endtask

  task automatic compare();
    chk("char_Y[dflt]", int'(y0), my[0]);
    chk("state[dflt]", int'(st0), mst[0]);
    chk("airborne[dflt]", int'(ab0), (mst[0] != 0) ? 1 : 0);
    chk("land[dflt]", int'(ld0), ld_m[0]);
    chk("char_Y[ymin]", int'(y1), my[1]);
    chk("state[ymin]", int'(st1), mst[1]);
    chk("airborne[ymin]", int'(ab1), (mst[1] != 0) ? 1 : 0);
    chk("land[ymin]", int'(ld1), ld_m[1]);
  endtask

  task automatic do_cycle(input logic t);
    tick = t;
    @(posedge sys_clk);
    model_update();
    #1;
    compare();
    tick = 1'b0;
  endtask

  task automatic tk();
    do_cycle(1'b1);
    do_cycle(1'b0);
  endtask

  task automatic wait_ground(input string name, input int max_ticks);
    int done = 0;
    for (int n = 0; n < max_ticks && done == 0; n++) begin
      if (st0 == 2'd0 && st1 == 2'd0) done = 1;
      else tk();
    end
    chk(name, (st0 == 2'd0 && st1 == 2'd0) ? 1 : 0, 1);
  endtask

  initial begin
    int done;
    sys_rst = 1'b1; tick = 1'b0; btn_jump = 1'b0; spring_jump = 1'b0;
    on_ground = 1'b1; hit_ceiling = 1'b0;
    do_cycle(1'b0);
    do_cycle(1'b0);
    chk("rst_y", int'(y0), 200);
    chk("rst_state", int'(st0), 0);
    chk("rst_airborne", int'(ab0), 0);
    chk("rst_land", int'(ld0), 0);
    sys_rst = 1'b0;
    do_cycle(1'b0);

    // Button jump from rest: edge captured, then launch tick
    btn_jump = 1'b1;
    do_cycle(1'b0);
    do_cycle(1'b1);
    chk("launch_state", int'(st0), 1);
    chk("launch_y", int'(y0), 200);
    btn_jump = 1'b0; on_ground = 1'b0;
    do_cycle(1'b0);
    for (int i = 0; i < 12; i++) begin
      do_cycle(1'b1);
      if (i == 0) begin
        chk("rise1_y", int'(y0), 188);
        chk("rise1_model_y", my[0], 188);
      end
      if (i == 4) begin
        chk("ymin_clamp_y", int'(y1), 150);
        chk("ymin_clamp_state", int'(st1), 2);
      end
      do_cycle(1'b0);
    end
    chk("apex_y", int'(y0), 122);
    chk("apex_state", int'(st0), 2);
    chk("apex_model_y", my[0], 122);
    done = 0;
    for (int n = 0; n < 40 && done == 0; n++) begin
      do_cycle(1'b1);
      if (st0 == 2'd0) done = 1;
      else do_cycle(1'b0);
    end
    chk("fall_land_reached", done, 1);
    chk("land_y", int'(y0), 200);
    chk("land_pulse", int'(ld0), 1);
    do_cycle(1'b0);
    chk("land_pulse_gone", int'(ld0), 0);
    wait_ground("ground_after_jump1", 40);

    // Ceiling, then spring bounce out of FALL
    on_ground = 1'b1; btn_jump = 1'b1;
    do_cycle(1'b1);
    btn_jump = 1'b0; on_ground = 1'b0;
    do_cycle(1'b0);
    tk(); tk();
    chk("pre_ceiling_y", int'(y0), 177);
    hit_ceiling = 1'b1;
    do_cycle(1'b1);
    hit_ceiling = 1'b0;
    chk("ceiling_state", int'(st0), 2);
    chk("ceiling_y", int'(y0), 177);
    do_cycle(1'b0);
    tk();
    chk("ceiling_fall0_y", int'(y0), 177);
    tk();
    chk("ceiling_fall1_y", int'(y0), 178);
    tk();
    chk("ceiling_fall2_y", int'(y0), 180);
    spring_jump = 1'b1;
    do_cycle(1'b1);
    spring_jump = 1'b0;
    chk("bounce_state", int'(st0), 1);
    chk("bounce_y", int'(y0), 180);
    do_cycle(1'b0);
    tk();
    chk("bounce_rise_y", int'(y0), 160);
    chk("bounce_model_y", my[0], 160);
    wait_ground("ground_after_bounce", 80);

    // Spring and button together from GROUND: spring speed wins; button held through landing
    on_ground = 1'b1; btn_jump = 1'b1; spring_jump = 1'b1;
    do_cycle(1'b1);
    spring_jump = 1'b0; on_ground = 1'b0;
    do_cycle(1'b0);
    tk();
    chk("spring_prio_y", int'(y0), 180);
    wait_ground("ground_after_spring", 80);
    tk(); tk(); tk();
    chk("held_no_relaunch", int'(st0), 0);
    btn_jump = 1'b0;
    do_cycle(1'b0);
    btn_jump = 1'b1;
    do_cycle(1'b1);
    chk("repress_launch", int'(st0), 1);
    btn_jump = 1'b0;
    do_cycle(1'b0);
    for (int i = 0; i < 14; i++) tk();
    on_ground = 1'b1;
    do_cycle(1'b1);
    chk("platform_land_state", int'(st0), 0);
    chk("platform_land_y", int'(y0), 123);
    chk("platform_land_pulse", int'(ld0), 1);
    do_cycle(1'b0);
    on_ground = 1'b0;
    tk();
    chk("ledge_fall_state", int'(st0), 2);
    wait_ground("ground_after_ledge", 80);

    // Press and release between ticks still launches
    btn_jump = 1'b1;
    do_cycle(1'b0);
    btn_jump = 1'b0;
    do_cycle(1'b0);
    do_cycle(1'b1);
    chk("tap_launch", int'(st0), 1);
    do_cycle(1'b0);

    // Reset mid-jump
    tk(); tk(); tk();
    chk("pre_reset_y", int'(y0), 167);
    chk("pre_reset_state", int'(st0), 1);
    sys_rst = 1'b1;
    do_cycle(1'b0);
    sys_rst = 1'b0;
    chk("midrst_y", int'(y0), 200);
    chk("midrst_state", int'(st0), 0);
    chk("midrst_airborne", int'(ab0), 0);
    chk("midrst_land", int'(ld0), 0);
    do_cycle(1'b0);
    tk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
